// File: rtl/bin_to_bcd_seq_if.sv
// bin_to_bcd_seq_if: start/value request and BCD result bus for bin_to_bcd_seq.
interface bin_to_bcd_seq_if #(
   parameter int BIN_W  = 9,
   parameter int DIGITS = 4
);
   logic                start_i;
   logic [BIN_W-1:0]    bin_i;
   logic                busy_o;
   logic                done_o;
   logic [4*DIGITS-1:0] bcd_o;
   logic                ovf_o;
   logic [DIGITS-1:0]   blank_o;
   modport master (output start_i, bin_i, input busy_o, done_o, bcd_o, ovf_o, blank_o);
   modport slave  (input start_i, bin_i, output busy_o, done_o, bcd_o, ovf_o, blank_o);
endinterface

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential double-dabble binary to packed BCD, one bit per clock, saturating on overflow.
// Leading-zero blanking is built only when BIN_TO_BCD_BLANK_EN is defined.
module bin_to_bcd_seq #(
   parameter int BIN_W  = 9,
   parameter int DIGITS = 4
) (
   input logic CLK,
   input logic RST,
   bin_to_bcd_seq_if.slave bus
);
   localparam int CW = $clog2(BIN_W + 1);
   localparam int AW = 4 * DIGITS;
   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
   state_t           state_q, state_d;
   logic [AW-1:0]    acc_q, acc_d, adj, res, bcd_q, bcd_d;
   logic [BIN_W-1:0] sh_q, sh_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             sticky_q, sticky_d, busy_q, busy_d, done_q, done_d, ovf_q, ovf_d;
   for (genvar i = 0; i < DIGITS; i++) begin : g_adj
      assign adj[4*i+:4] = acc_q[4*i+:4] >= 4'd5 ? acc_q[4*i+:4] + 4'd3 : acc_q[4*i+:4];
   end
   assign res = sticky_q ? {DIGITS{4'h9}} : acc_q;
   always_ff @(posedge CLK or posedge RST)
      if (RST) begin
         state_q  <= S_IDLE;
         acc_q    <= '0;
         sh_q     <= '0;
         cnt_q    <= '0;
         sticky_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         bcd_q    <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         sh_q     <= sh_d;
         cnt_q    <= cnt_d;
         sticky_q <= sticky_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         bcd_q    <= bcd_d;
         ovf_q    <= ovf_d;
      end
   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      sh_d     = sh_q;
      cnt_d    = cnt_q;
      sticky_d = sticky_q;
      if (state_q == S_IDLE && bus.start_i) begin
         state_d  = S_SHIFT;
         acc_d    = '0;
         sh_d     = bus.bin_i;
         cnt_d    = '0;
         sticky_d = 1'b0;
      end else if (state_q == S_SHIFT) begin
         state_d  = cnt_q == CW'(BIN_W - 1) ? S_DONE : S_SHIFT;
         acc_d    = {adj[AW-2:0], sh_q[BIN_W-1]};
         sh_d     = sh_q << 1;
         cnt_d    = cnt_q + CW'(1);
         sticky_d = sticky_q | adj[AW-1];
      end else if (state_q == S_DONE) begin
         state_d  = S_IDLE;
      end
   end
   // outputs are registered one cycle behind the state so BUSY and DONE never overlap
   always_comb begin
      busy_d = state_q == S_SHIFT;
      done_d = state_q == S_DONE;
      bcd_d  = done_d ? res : bcd_q;
      ovf_d  = done_d ? sticky_q : ovf_q;
   end
   assign bus.busy_o = busy_q;
   assign bus.done_o = done_q;
   assign bus.bcd_o  = bcd_q;
   assign bus.ovf_o  = ovf_q;
`ifdef BIN_TO_BCD_BLANK_EN
   logic [DIGITS-1:0] blank_q, blank_n;
   always_comb begin
      logic z;
      z       = 1'b1;
      blank_n = '0;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         z          = z & (res[4*i+:4] == 4'd0);
         blank_n[i] = z;
      end
   end
   always_ff @(posedge CLK or posedge RST)
      if (RST) blank_q <= '0;
      else if (state_q == S_DONE) blank_q <= blank_n;
   assign bus.blank_o = blank_q;
`else
   assign bus.blank_o = '0;
`endif
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: directed checks of bin_to_bcd_seq at 9-bit and 16-bit widths.
module tb_bin_to_bcd_seq;
   logic CLK = 1'b0;
   logic RST = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;
`ifdef BIN_TO_BCD_BLANK_EN
   localparam logic [3:0] BL_1000 = 4'b1000, BL_1100 = 4'b1100, BL_1110 = 4'b1110;
`else
   localparam logic [3:0] BL_1000 = 4'b0000, BL_1100 = 4'b0000, BL_1110 = 4'b0000;
`endif
   bin_to_bcd_seq_if #(.BIN_W(9),  .DIGITS(4)) b9 ();
   bin_to_bcd_seq_if #(.BIN_W(16), .DIGITS(4)) b16 ();
   bin_to_bcd_seq #(.BIN_W(9),  .DIGITS(4)) u9  (.CLK(CLK), .RST(RST), .bus(b9));
   bin_to_bcd_seq #(.BIN_W(16), .DIGITS(4)) u16 (.CLK(CLK), .RST(RST), .bus(b16));
   always #5 CLK = ~CLK;
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask
   task automatic convert9(input logic [8:0] v, output bit got);
      b9.bin_i   = v;
      b9.start_i = 1'b1;
      tick();
      b9.start_i = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         tick();
         got = b9.done_o;
      end
   endtask
   task automatic convert16(input logic [15:0] v, output bit got);
      b16.bin_i   = v;
      b16.start_i = 1'b1;
      tick();
      b16.start_i = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 30 && !got; i++) begin
         tick();
         got = b16.done_o;
      end
   endtask
   task automatic test_reset();
      tick();
      tick();
      n_cmp++;
      if ({b9.busy_o, b9.done_o, b9.bcd_o, b9.ovf_o, b9.blank_o} !== 23'd0) begin
         n_err++;
         $display("FAIL reset9: got %h want 0", {b9.busy_o, b9.done_o, b9.bcd_o, b9.ovf_o, b9.blank_o});
      end
      n_cmp++;
      if ({b16.busy_o, b16.done_o, b16.bcd_o, b16.ovf_o, b16.blank_o} !== 23'd0) begin
         n_err++;
         $display("FAIL reset16: got %h want 0", {b16.busy_o, b16.done_o, b16.bcd_o, b16.ovf_o, b16.blank_o});
      end
      RST = 1'b0;
      tick();
   endtask
   task automatic test_latency();
      b9.bin_i   = 9'd511;
      b9.start_i = 1'b1;
      tick();
      b9.start_i = 1'b0;
      for (int i = 1; i <= 9; i++) begin
         tick();
         n_cmp++;
         if ({b9.busy_o, b9.done_o} !== 2'b10) begin
            n_err++;
            $display("FAIL lat_busy cycle %0d: got busy/done %b want 10", i, {b9.busy_o, b9.done_o});
         end
      end
      tick();
      n_cmp++;
      if ({b9.busy_o, b9.done_o} !== 2'b01) begin
         n_err++;
         $display("FAIL lat_done: got busy/done %b want 01", {b9.busy_o, b9.done_o});
      end
      n_cmp++;
      if ({b9.bcd_o, b9.ovf_o, b9.blank_o} !== {16'h0511, 1'b0, BL_1000}) begin
         n_err++;
         $display("FAIL lat_511: got bcd %h ovf %b blank %b want 0511 0 %b", b9.bcd_o, b9.ovf_o, b9.blank_o, BL_1000);
      end
      tick();
      n_cmp++;
      if ({b9.done_o, b9.bcd_o} !== {1'b0, 16'h0511}) begin
         n_err++;
         $display("FAIL lat_pulse: got done %b bcd %h want 0 0511", b9.done_o, b9.bcd_o);
      end
   endtask
   task automatic test_back_to_back();
      bit got;
      int gap;
      b9.bin_i   = 9'd0;
      b9.start_i = 1'b1;
      tick();
      b9.bin_i = 9'd99;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         tick();
         got = b9.done_o;
      end
      n_cmp++;
      if ({got, b9.bcd_o, b9.ovf_o, b9.blank_o} !== {1'b1, 16'h0000, 1'b0, BL_1110}) begin
         n_err++;
         $display("FAIL b2b_0: got done %b bcd %h ovf %b blank %b want 1 0000 0 %b", got, b9.bcd_o, b9.ovf_o, b9.blank_o, BL_1110);
      end
      got = 1'b0;
      gap = 0;
      for (int i = 0; i < 20 && !got; i++) begin
         tick();
         gap++;
         got = b9.done_o;
      end
      b9.start_i = 1'b0;
      n_cmp++;
      if (gap !== 11 || !got) begin
         n_err++;
         $display("FAIL b2b_gap: got %0d cycles (done %b) want 11", gap, got);
      end
      n_cmp++;
      if ({b9.bcd_o, b9.blank_o} !== {16'h0099, BL_1100}) begin
         n_err++;
         $display("FAIL b2b_99: got bcd %h blank %b want 0099 %b", b9.bcd_o, b9.blank_o, BL_1100);
      end
      tick();
   endtask
   task automatic test_overflow();
      bit got;
      convert16(16'd65535, got);
      n_cmp++;
      if ({got, b16.bcd_o, b16.ovf_o, b16.blank_o} !== {1'b1, 16'h9999, 1'b1, 4'b0000}) begin
         n_err++;
         $display("FAIL ovf_65535: got done %b bcd %h ovf %b blank %b want 1 9999 1 0000", got, b16.bcd_o, b16.ovf_o, b16.blank_o);
      end
      convert16(16'd9999, got);
      n_cmp++;
      if ({got, b16.bcd_o, b16.ovf_o, b16.blank_o} !== {1'b1, 16'h9999, 1'b0, 4'b0000}) begin
         n_err++;
         $display("FAIL ovf_9999: got done %b bcd %h ovf %b blank %b want 1 9999 0 0000", got, b16.bcd_o, b16.ovf_o, b16.blank_o);
      end
      convert16(16'd10000, got);
      n_cmp++;
      if ({got, b16.bcd_o, b16.ovf_o} !== {1'b1, 16'h9999, 1'b1}) begin
         n_err++;
         $display("FAIL ovf_10000: got done %b bcd %h ovf %b want 1 9999 1", got, b16.bcd_o, b16.ovf_o);
      end
      convert16(16'd1234, got);
      n_cmp++;
      if ({got, b16.bcd_o, b16.ovf_o} !== {1'b1, 16'h1234, 1'b0}) begin
         n_err++;
         $display("FAIL ovf_1234: got done %b bcd %h ovf %b want 1 1234 0", got, b16.bcd_o, b16.ovf_o);
      end
   endtask
   task automatic test_ignore();
      int ndone;
      b9.bin_i   = 9'd123;
      b9.start_i = 1'b1;
      tick();
      b9.start_i = 1'b0;
      tick();
      tick();
      b9.start_i = 1'b1;
      b9.bin_i   = 9'd77;
      tick();
      tick();
      tick();
      b9.start_i = 1'b0;
      ndone = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         ndone += int'(b9.done_o);
      end
      n_cmp++;
      if (ndone !== 1) begin
         n_err++;
         $display("FAIL ign_count: got %0d done pulses want 1", ndone);
      end
      n_cmp++;
      if ({b9.bcd_o, b9.ovf_o} !== {16'h0123, 1'b0}) begin
         n_err++;
         $display("FAIL ign_value: got bcd %h ovf %b want 0123 0", b9.bcd_o, b9.ovf_o);
      end
   endtask
   task automatic test_abort();
      bit got;
      int ndone;
      b9.bin_i   = 9'd300;
      b9.start_i = 1'b1;
      tick();
      b9.start_i = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      RST = 1'b1;
      #1;
      n_cmp++;
      if ({b9.busy_o, b9.done_o, b9.bcd_o, b9.ovf_o, b9.blank_o} !== 23'd0) begin
         n_err++;
         $display("FAIL abort9: got %h want 0", {b9.busy_o, b9.done_o, b9.bcd_o, b9.ovf_o, b9.blank_o});
      end
      n_cmp++;
      if ({b16.bcd_o, b16.ovf_o} !== 17'd0) begin
         n_err++;
         $display("FAIL abort16: got bcd %h ovf %b want 0000 0", b16.bcd_o, b16.ovf_o);
      end
      tick();
      RST = 1'b0;
      ndone = 0;
      for (int i = 0; i < 15; i++) begin
         tick();
         ndone += int'(b9.done_o);
      end
      n_cmp++;
      if (ndone !== 0) begin
         n_err++;
         $display("FAIL abort_done: got %0d done pulses want 0", ndone);
      end
      convert9(9'd200, got);
      n_cmp++;
      if ({got, b9.bcd_o, b9.ovf_o, b9.blank_o} !== {1'b1, 16'h0200, 1'b0, BL_1000}) begin
         n_err++;
         $display("FAIL abort_next: got done %b bcd %h ovf %b blank %b want 1 0200 0 %b", got, b9.bcd_o, b9.ovf_o, b9.blank_o, BL_1000);
      end
   endtask
   task automatic test_blank();
      bit got;
      convert9(9'd42, got);
      n_cmp++;
      if ({got, b9.bcd_o, b9.blank_o} !== {1'b1, 16'h0042, BL_1100}) begin
         n_err++;
         $display("FAIL blank_42: got done %b bcd %h blank %b want 1 0042 %b", got, b9.bcd_o, b9.blank_o, BL_1100);
      end
      convert9(9'd5, got);
      n_cmp++;
      if ({got, b9.bcd_o, b9.blank_o} !== {1'b1, 16'h0005, BL_1110}) begin
         n_err++;
         $display("FAIL blank_5: got done %b bcd %h blank %b want 1 0005 %b", got, b9.bcd_o, b9.blank_o, BL_1110);
      end
      convert9(9'd100, got);
      n_cmp++;
      if ({got, b9.bcd_o, b9.blank_o} !== {1'b1, 16'h0100, BL_1000}) begin
         n_err++;
         $display("FAIL blank_100: got done %b bcd %h blank %b want 1 0100 %b", got, b9.bcd_o, b9.blank_o, BL_1000);
      end
   endtask
   initial begin
      b9.start_i  = 1'b0;
      b9.bin_i    = '0;
      b16.start_i = 1'b0;
      b16.bin_i   = '0;
      test_reset();
      test_latency();
      test_back_to_back();
      test_overflow();
      test_ignore();
      test_abort();
      test_blank();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
